// File: rtl/ahb_dmem_slave.sv
// rtl/ahb_dmem_slave.sv - AHB-Lite data-memory slave with wait states and lane-masked writes
`timescale 1ns/1ps
module ahb_dmem_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              err_in;
    logic              done;
    logic              take;
    logic [3:0]        be;
    logic              unused_haddr;

    // Upper address bits are ignored so accesses wrap modulo the array size
    assign unused_haddr = ^haddr[31:ADDR_W+2];

    assign accept = hsel & htrans[1] & hready;
    assign err_in = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
    assign done   = (state_q == S_DATA) && (wcnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE, S_ERR2: take = 1'b1;
            S_DATA: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    take = 1'b1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        // A new address phase is only honoured when the slave is free this cycle
        if (take) begin
            if (accept) begin
                addr_d  = haddr[ADDR_W+1:0];
                write_d = hwrite;
                size_d  = hsize;
                if (err_in) begin
                    state_d = S_ERR1;
                    wcnt_d  = 4'd0;
                end else begin
                    state_d = S_DATA;
                    wcnt_d  = 4'(WAIT_STATES);
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be[addr_q[1:0]] = 1'b1;
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array is deliberately outside the reset domain so contents survive rst
    always_ff @(posedge clk) begin
        if (!rst && done && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hreadyout = !((state_q == S_ERR1) || ((state_q == S_DATA) && (wcnt_q != 4'd0)));
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem[addr_q[ADDR_W+1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// tb/tb_ahb_dmem_slave.sv - scoreboard bench for ahb_dmem_slave (instances with 0 and 1 wait states)
`timescale 1ns/1ps
module tb_ahb_dmem_slave;
    localparam int ADDR_W = 10;
    localparam int MBYTES = 4 << ADDR_W;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        hsel_a      [2];
    logic [31:0] haddr_a     [2];
    logic [1:0]  htrans_a    [2];
    logic        hwrite_a    [2];
    logic [2:0]  hsize_a     [2];
    logic [31:0] hwdata_a    [2];
    logic        hready_a    [2];
    logic        nready_a    [2];
    logic        hreadyout_a [2];
    logic        hresp_a     [2];
    logic [31:0] hrdata_a    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign hready_a[g] = nready_a[g] ? 1'b0 : hreadyout_a[g];
        ahb_dmem_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .hsel      (hsel_a[g]),
            .haddr     (haddr_a[g]),
            .htrans    (htrans_a[g]),
            .hwrite    (hwrite_a[g]),
            .hsize     (hsize_a[g]),
            .hwdata    (hwdata_a[g]),
            .hready    (hready_a[g]),
            .hreadyout (hreadyout_a[g]),
            .hresp     (hresp_a[g]),
            .hrdata    (hrdata_a[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [2][MBYTES];
    exp_t q0[$];
    exp_t q1[$];

    function automatic int ws(input int i);
        return i;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_word(input int i, input logic [31:0] a);
        int b;
        b = int'(a[ADDR_W+1:0]) & ~3;
        return {mdl[i][b+3], mdl[i][b+2], mdl[i][b+1], mdl[i][b]};
    endfunction

    function automatic void model_write(input int i, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int n;
        int base;
        n    = 1 << s;
        base = int'(a[ADDR_W+1:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) mdl[i][base+k] = d[8*((base+k)%4) +: 8];
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        exp_t e;
        int   n;
        e.err   = model_err(a, s);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (w) model_write(i, a, s, d);
            else   e.rdata = model_word(i, a);
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        hsel_a[i]   = 1'b1;
        htrans_a[i] = 2'b10;
        haddr_a[i]  = a;
        hwrite_a[i] = w;
        hsize_a[i]  = s;
        n = 0;
        @(negedge clk);
        while (hready_a[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout inst=%0d actual=no_ready required=ready", i);
        end
        @(posedge clk);
        #1;
        hwdata_a[i] = d;
    endtask

    task automatic idle(input int i, input int cycles, input logic sel, input logic [1:0] tr);
        hsel_a[i]   = sel;
        htrans_a[i] = tr;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic monitor(input int i);
        exp_t cur;
        bit   active;
        int   waits;
        int   bad_resp;
        active   = 0;
        waits    = 0;
        bad_resp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                if (i == 0) q0.delete();
                else        q1.delete();
                continue;
            end
            if (active) begin
                if (hreadyout_a[i] !== 1'b1) begin
                    waits++;
                    if (hresp_a[i] !== cur.err) bad_resp++;
                    if (waits > 20) begin
                        checks++;
                        failures++;
                        $display("FAIL data_phase_timeout inst=%0d actual=%0d_waits", i, waits);
                        active = 0;
                    end
                end else begin
                    check("hresp", i, 32'(hresp_a[i]), 32'(cur.err));
                    check("wait_cycles", i, 32'(waits), cur.err ? 32'd1 : 32'(ws(i)));
                    check("wait_hresp", i, 32'(bad_resp), 32'd0);
                    check("hrdata", i, hrdata_a[i], cur.rdata);
                    active = 0;
                end
            end else begin
                check("idle_hreadyout", i, 32'(hreadyout_a[i]), 32'd1);
                check("idle_hresp", i, 32'(hresp_a[i]), 32'd0);
                check("idle_hrdata", i, hrdata_a[i], 32'd0);
            end
            if (hsel_a[i] === 1'b1 && htrans_a[i][1] === 1'b1 && hready_a[i] === 1'b1) begin
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_accept inst=%0d actual=accept required=none", i);
                end else begin
                    cur      = (i == 0) ? q0.pop_front() : q1.pop_front();
                    active   = 1;
                    waits    = 0;
                    bad_resp = 0;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic random_run(input int i, input int n);
        logic [31:0] a;
        logic [2:0]  s;
        logic        w;
        for (int k = 0; k < n; k++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            s = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            w = 1'($urandom_range(0, 1));
            issue(i, a, w, s, $urandom);
            if ($urandom_range(0, 3) == 0) idle(i, $urandom_range(1, 2), 1'b0, 2'b00);
        end
        idle(i, 4, 1'b0, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] saved [4];
        for (int i = 0; i < 2; i++) begin
            hsel_a[i] = 1'b0; haddr_a[i] = '0; htrans_a[i] = 2'b00; hwrite_a[i] = 1'b0;
            hsize_a[i] = 3'd0; hwdata_a[i] = '0; nready_a[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) issue(i, 32'(k * 4), 1'b1, 3'd2, $urandom);
            idle(i, 3, 1'b0, 2'b00);
        end

        issue(1, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        issue(1, 32'h10, 1'b0, 3'd2, $urandom);
        idle(1, 2, 1'b0, 2'b00);
        issue(1, 32'h13, 1'b1, 3'd0, 32'hAA00_0000);
        issue(1, 32'h10, 1'b1, 3'd1, 32'h0000_5566);
        issue(1, 32'h10, 1'b0, 3'd2, $urandom);
        idle(1, 2, 1'b0, 2'b00);
        issue(1, 32'h21, 1'b1, 3'd1, 32'h1234_5678);
        issue(1, 32'h22, 0, 3'd2, $urandom);
        issue(1, 32'h20, 0, 3'd2, $urandom);
        idle(1, 2, 1'b0, 2'b00);

        nready_a[1] = 1'b1;
        hsel_a[1] = 1'b1; htrans_a[1] = 2'b10; haddr_a[1] = 32'h20; hwrite_a[1] = 1'b1;
        hsize_a[1] = 3'd2; hwdata_a[1] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 nready_a[1] = 1'b0;
        idle(1, 3, 1'b1, 2'b00);
        idle(1, 3, 1'b1, 2'b01);
        idle(1, 1, 1'b0, 2'b00);
        issue(1, 32'h20, 1'b0, 3'd2, $urandom);
        idle(1, 2, 1'b0, 2'b00);

        for (int k = 0; k < 4; k++) saved[k] = mdl[1][32'h30 + k];
        issue(1, 32'h30, 1'b1, 3'd2, 32'hCAFE_F00D);
        hsel_a[1] = 1'b0; htrans_a[1] = 2'b00;
        check("pre_rst_wait", 1, 32'(hreadyout_a[1]), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_hreadyout", 1, 32'(hreadyout_a[1]), 32'd1);
        check("rst_hresp", 1, 32'(hresp_a[1]), 32'd0);
        check("rst_hrdata", 1, hrdata_a[1], 32'd0);
        for (int k = 0; k < 4; k++) mdl[1][32'h30 + k] = saved[k];
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        issue(1, 32'h30, 1'b0, 3'd2, $urandom);
        idle(1, 2, 1'b0, 2'b00);

        for (int k = 0; k < 4; k++) issue(0, 32'(k * 4), 1'b1, 3'd2, $urandom);
        for (int k = 0; k < 4; k++) issue(0, 32'(k * 4), 1'b0, 3'd2, $urandom);
        idle(0, 3, 1'b0, 2'b00);

        random_run(0, 80);
        random_run(1, 80);

        check("queues_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_dmem_slave.md
# ahb_dmem_slave

AHB-Lite data-memory responder: the slave end of the transfers that the memory stage issues from its pipelined `i_start`/`i_hsize`/`i_htrans` controls. It decodes each address phase, inserts a configurable number of wait states, and performs lane-masked byte, halfword and word writes into an internal word array. It returns aligned read words, which the memory stage then extracts and sign- or zero-extends. Misaligned or unsupported sizes get a two-cycle ERROR response.

## Interface
- `ADDR_W`, 10: log2 of memory depth in 32-bit words; the array holds 2^ADDR_W words.
- `WAIT_STATES`, 1: data-phase wait cycles per OKAY transfer; range 0..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hsel`  in  1  slave select.
- `haddr`  in  32  byte address.
- `htrans`  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  0 byte, 1 halfword, 2 word; values 3..7 are unsupported.
- `hwdata`  in  32  write data, valid during the data phase.
- `hready`  in  1  bus-level ready; an address phase is sampled only when this is high.
- `hreadyout`  out  1  slave ready for the current data phase.
- `hresp`  out  1  0 OKAY, 1 ERROR.
- `hrdata`  out  32  read word, full 32 bits, lane-aligned.

## Operation
- Accept condition: `hsel & htrans[1] & hready` on a rising edge. On accept, register `haddr[ADDR_W+1:0]`, `hwrite`, `hsize`, and an error flag. IDLE and BUSY transfers are never accepted; they get a zero-wait OKAY.
- Error flag is set when any of these holds:
  - `hsize > 2`;
  - `hsize == 1` and `haddr[0] == 1`;
  - `hsize == 2` and `haddr[1:0] != 0`.
- Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo the memory size.
- States:
  - IDLE: `hreadyout=1`, `hresp=0`. An accept with the error flag clear moves to DATA and loads `wcnt = WAIT_STATES`. An accept with the error flag set moves to ERR1.
  - DATA: `hreadyout = (wcnt == 0)`. While `wcnt != 0`, decrement `wcnt`. When `wcnt == 0`, the transfer completes this cycle.
  - On DATA completion:
    - A new accept in the same cycle reloads DATA (or enters ERR1 if its error flag is set).
    - Otherwise the next state is IDLE.
  - ERR1: `hreadyout=0`, `hresp=1`. Always moves to ERR2.
  - ERR2: `hreadyout=1`, `hresp=1`. A new accept in this cycle is honoured exactly as in IDLE; otherwise the next state is IDLE.
- Write happens at the DATA completion edge only. Byte enables:
  - byte: lane `addr[1:0]`;
  - halfword: lanes {1,0} when `addr[1]=0`, lanes {3,2} when `addr[1]=1`;
  - word: all four lanes.
  - `hwdata` is taken unshifted, on its native lanes.
- Read: `hrdata = mem[addr[ADDR_W+1:2]]` while in DATA with a read registered, and 0 otherwise. It is valid in the cycle where `hreadyout=1`.
- Errored transfers never modify memory.
- Memory contents are not reset and are preserved across `rst`.

## Timing
- Reset values: state IDLE, `hreadyout=1`, `hresp=0`, `hrdata=0`, `wcnt=0`, all registered address/control cleared.
- Asserting `rst` mid-transfer aborts the transfer immediately. Any pending write is dropped.
- OKAY latency: the data phase lasts `WAIT_STATES+1` cycles after the accept edge.
- With `WAIT_STATES=0`, back-to-back NONSEQ transfers sustain one transfer per cycle.
- Read-after-write to the same word in consecutive transfers returns the new data, because the write commits at the edge before the read's data phase.
- ERROR response is always exactly 2 cycles, regardless of `WAIT_STATES`.
- With `hready=0` from another slave, no accept occurs and the state is unchanged when in IDLE.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10 followed by a read of 0x10 with `WAIT_STATES=1`:
  - write data phase shows `hreadyout` 0 then 1;
  - read returns `hrdata=0xDEADBEEF` on the cycle `hreadyout=1`.
- Byte write 0xAA to 0x13, then halfword write 0x5566 to 0x10, then read word 0x10 → `0xAAxx5566`, with lane 2 unchanged from its prior value.
- Halfword write to 0x21 and word read from 0x22:
  - each gives `hresp=1` with `hreadyout=0` then 1;
  - a following read of 0x20 shows the memory unchanged.
- `WAIT_STATES=0`: four back-to-back NONSEQ word writes to 0x0, 0x4, 0x8, 0xC, then four reads:
  - `hreadyout` stays 1 throughout;
  - data matches in order.
- IDLE or BUSY with `hsel=1`, and NONSEQ with `hready=0` → no state change, `hreadyout=1`, `hresp=0`, memory unchanged.
- Assert `rst` during a write's wait state → outputs return to reset values immediately, and a later read of that address shows the old data.
